// File: rtl/seq_mult.sv
// Sequential radix-2 shift-add multiplier producing the full 2*WIDTH product.
// Signed operands are reduced to magnitudes, multiplied unsigned, and the
// result is negated when the operand signs differ.
// Optional feature: define SEQ_MULT_EARLY_OUT_EN to leave RUN as soon as the
// remaining multiplier magnitude bits are all zero (results are unchanged).
module seq_mult #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             doSigned,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] mult_low,
  output logic [WIDTH-1:0] mult_high
);

  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e             state_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic               neg_q;
  logic [CntW-1:0]    cnt_q;

  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic               neg_in;
  logic [2*WIDTH-1:0] acc_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic               last_bit;

  // Operand magnitudes, next accumulator value, sign fix-up and RUN exit test.
  always_comb begin
    // Two's-complement negation of the most-negative value yields 2^(WIDTH-1)
    // when read back as unsigned, so the magnitude is exact.
    a_mag    = (doSigned && A[WIDTH-1]) ? -A : A;
    b_mag    = (doSigned && B[WIDTH-1]) ? -B : B;
    neg_in   = doSigned && (A[WIDTH-1] ^ B[WIDTH-1]);
    acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);
    prod_fix = neg_q ? -acc_next : acc_next;
    last_bit = (cnt_q == CntW'(WIDTH - 1));
`ifdef SEQ_MULT_EARLY_OUT_EN
    // Bit 0 is retired this cycle; stop if nothing above it remains.
    last_bit = last_bit || (mplier_q[WIDTH-1:1] == '0);
`endif
  end

  // Control FSM, datapath iteration and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      busy      <= 1'b0;
      done      <= 1'b0;
      mult_low  <= '0;
      mult_high <= '0;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      neg_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          done <= 1'b0;
          if (start) begin
            state_q  <= StRun;
            busy     <= 1'b1;
            acc_q    <= '0;
            mcand_q  <= {{WIDTH{1'b0}}, a_mag};
            mplier_q <= b_mag;
            neg_q    <= neg_in;
            cnt_q    <= '0;
          end else begin
            state_q <= StIdle;
            busy    <= 1'b0;
          end
        end
        StRun: begin
          acc_q    <= acc_next;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CntW'(1);
          if (last_bit) begin
            state_q   <= StDone;
            busy      <= 1'b0;
            done      <= 1'b1;
            mult_high <= prod_fix[2*WIDTH-1:WIDTH];
            mult_low  <= prod_fix[WIDTH-1:0];
          end
        end
        default: begin
          state_q <= StIdle;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule
